// File: rtl/fetch_timing_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_timing_unit_pkg
// Shared definitions for the fetch/timing stage and the downstream decoder:
//   - machine cycle phase encodings CYC_A1..CYC_X3
//   - first-word OPR values of the two-word instructions
//   - word-position state type for the fetch state machine
//   - isTwoWord(): classifies a first word as the start of a two-word instruction
// -----------------------------------------------------------------------------
package fetch_timing_unit_pkg;

   localparam logic [2:0] CYC_A1 = 3'd0;
   localparam logic [2:0] CYC_A2 = 3'd1;
   localparam logic [2:0] CYC_A3 = 3'd2;
   localparam logic [2:0] CYC_M1 = 3'd3;
   localparam logic [2:0] CYC_M2 = 3'd4;
   localparam logic [2:0] CYC_X1 = 3'd5;
   localparam logic [2:0] CYC_X2 = 3'd6;
   localparam logic [2:0] CYC_X3 = 3'd7;

   localparam logic [3:0] OPR_JCN = 4'h1;
   localparam logic [3:0] OPR_FIM = 4'h2;
   localparam logic [3:0] OPR_JUN = 4'h4;
   localparam logic [3:0] OPR_JMS = 4'h5;
   localparam logic [3:0] OPR_ISZ = 4'h7;

   typedef enum logic {
      WORD1 = 1'b0,
      WORD2 = 1'b1
   } wordState_t;

   // FIM shares OPR=2 with SRC; only an even OPA selects FIM.
   // Callers that treat FIM as one-word mask the FIM case themselves.
   function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
      logic fim;
      fim = (opr == OPR_FIM) && ((opa & 4'h1) == 4'h0);
      return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
             (opr == OPR_ISZ) || fim;
   endfunction

endpackage

// File: rtl/fetch_timing_unit_cycle_counter.sv
// -----------------------------------------------------------------------------
// cycle_counter
// Free-running 3-bit machine-cycle phase counter, A1 (0) through X3 (7),
// wrapping X3 -> A1. Holds while stalled.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset, forces A1
//   stallIn  in   holds the phase while high
//   cycle    out  current phase
//   sync     out  high during X3, announcing the next A1
// -----------------------------------------------------------------------------
module cycle_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       stallIn,
   output logic [2:0] cycle,
   output logic       sync
);
   import fetch_timing_unit_pkg::*;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle <= CYC_A1;
      end else if (!stallIn) begin
         cycle <= cycle + 3'd1;
      end
   end

   assign sync = (cycle == CYC_X3);

endmodule

// File: rtl/fetch_timing_unit.sv
// -----------------------------------------------------------------------------
// fetch_timing_unit
// Front end of the 4004-style core: runs the 8-phase machine cycle, puts the
// 12-bit PC out as three address nibbles, fetches OPR/OPA from the data bus
// and tracks whether the current instruction cycle is the second word of a
// two-word instruction.
//
// Parameters:
//   RESET_PC      PC value after reset
//   TWO_WORD_FIM  1: FIM (OPR=2, OPA even) fetches a second word; 0: one-word
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   stallIn     in   freezes all state while high
//   dataIn[3:0] in   ROM nibble, sampled leaving M1 and M2
//   jumpEn      in   load PC from jumpAddr at X3 of a final word
//   jumpAddr    in   jump target
//   cycle       out  phase A1=0 .. X3=7
//   sync        out  high in X3
//   addrOut     out  pc nibble for A1/A2/A3, zero otherwise
//   pc          out  program counter
//   opr, opa    out  first word of the current instruction
//   imm         out  second word {OPR2,OPA2}
//   secondWord  out  high for the whole instruction cycle fetching word 2
//
// Word state machine:
//   state | meaning
//   WORD1 | fetching a first word; opr/opa are loaded from the bus
//   WORD2 | fetching the second word; bus nibbles go to imm
// -----------------------------------------------------------------------------
module fetch_timing_unit #(
   parameter logic [11:0] RESET_PC     = 12'h000,
   parameter bit          TWO_WORD_FIM = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallIn,
   input  logic [3:0]  dataIn,
   input  logic        jumpEn,
   input  logic [11:0] jumpAddr,
   output logic [2:0]  cycle,
   output logic        sync,
   output logic [3:0]  addrOut,
   output logic [11:0] pc,
   output logic [3:0]  opr,
   output logic [3:0]  opa,
   output logic [7:0]  imm,
   output logic        secondWord
);
   import fetch_timing_unit_pkg::*;

   wordState_t wordState;
   logic       startsTwoWord;

   cycle_counter uCycle (
      .clk     (clk),
      .rst     (rst),
      .stallIn (stallIn),
      .cycle   (cycle),
      .sync    (sync)
   );

   assign startsTwoWord = isTwoWord(opr, opa) && (TWO_WORD_FIM || (opr != OPR_FIM));

   // The increment at A3 has already happened by X3, so a jump simply
   // replaces pc; at X3 of a first word of a two-word instruction the
   // jump request is not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         opr       <= 4'h0;
         opa       <= 4'h0;
         imm       <= 8'h00;
         wordState <= WORD1;
      end else if (!stallIn) begin
         case (cycle)
            CYC_A3: begin
               pc <= pc + 12'd1;
            end
            CYC_M1: begin
               if (wordState == WORD2) begin
                  imm[7:4] <= dataIn;
               end else begin
                  opr <= dataIn;
               end
            end
            CYC_M2: begin
               if (wordState == WORD2) begin
                  imm[3:0] <= dataIn;
               end else begin
                  opa <= dataIn;
               end
            end
            CYC_X3: begin
               if (wordState == WORD2) begin
                  wordState <= WORD1;
                  if (jumpEn) begin
                     pc <= jumpAddr;
                  end
               end else if (startsTwoWord) begin
                  wordState <= WORD2;
               end else if (jumpEn) begin
                  pc <= jumpAddr;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign secondWord = (wordState == WORD2);

   always_comb begin
      addrOut = 4'h0;
      case (cycle)
         CYC_A1:  addrOut = pc[3:0];
         CYC_A2:  addrOut = pc[7:4];
         CYC_A3:  addrOut = pc[11:8];
         default: addrOut = 4'h0;
      endcase
   end

endmodule

// File: tb/tb_fetch_timing_unit.sv
module tb_fetch_timing_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallIn;
   logic [3:0]  dataIn;
   logic        jumpEn;
   logic [11:0] jumpAddr;

   logic [2:0]  cycle;
   logic        sync;
   logic [3:0]  addrOut;
   logic [11:0] pc;
   logic [3:0]  opr, opa;
   logic [7:0]  imm;
   logic        secondWord;

   logic [2:0]  wCycle;
   logic        wSync;
   logic [3:0]  wAddrOut;
   logic [11:0] wPc;
   logic [3:0]  wOpr, wOpa;
   logic [7:0]  wImm;
   logic        wSecondWord;

   fetch_timing_unit dut (
      .clk(clk), .rst(rst), .stallIn(stallIn), .dataIn(dataIn),
      .jumpEn(jumpEn), .jumpAddr(jumpAddr),
      .cycle(cycle), .sync(sync), .addrOut(addrOut), .pc(pc),
      .opr(opr), .opa(opa), .imm(imm), .secondWord(secondWord)
   );

   fetch_timing_unit #(.RESET_PC(12'hFFF)) dutWrap (
      .clk(clk), .rst(rst), .stallIn(stallIn), .dataIn(dataIn),
      .jumpEn(jumpEn), .jumpAddr(jumpAddr),
      .cycle(wCycle), .sync(wSync), .addrOut(wAddrOut), .pc(wPc),
      .opr(wOpr), .opa(wOpa), .imm(wImm), .secondWord(wSecondWord)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst      = 1'b1;
      stallIn  = 1'b0;
      dataIn   = 4'h0;
      jumpEn   = 1'b0;
      jumpAddr = 12'h000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model (instruction-level view) -------------
   // An instruction occupies 8 unstalled clocks starting at address mStart;
   // the pc shown is mStart until the A3 edge, mStart+1 afterwards.
   int          mAct;
   int          mStart;
   bit          mW2;
   logic [3:0]  mOpr, mOpa;
   logic [7:0]  mImm;

   function automatic bit refTwoWord(input logic [3:0] o, input logic [3:0] a);
      return (o == 4'd1) || (o == 4'd4) || (o == 4'd5) || (o == 4'd7) ||
             (o == 4'd2 && a[0] == 1'b0);
   endfunction

   task automatic modelReset();
      mAct = 0; mStart = 0; mW2 = 1'b0; mOpr = 4'h0; mOpa = 4'h0; mImm = 8'h00;
   endtask

   task automatic modelEdge();
      int ph;
      if (stallIn) return;
      ph = mAct % 8;
      if (ph == 3) begin
         if (mW2) mImm[7:4] = dataIn; else mOpr = dataIn;
      end else if (ph == 4) begin
         if (mW2) mImm[3:0] = dataIn; else mOpa = dataIn;
      end else if (ph == 7) begin
         if (!mW2 && refTwoWord(mOpr, mOpa)) begin
            mW2 = 1'b1;
            mStart = (mStart + 1) % 4096;
         end else begin
            mW2 = 1'b0;
            mStart = jumpEn ? int'(jumpAddr) : (mStart + 1) % 4096;
         end
      end
      mAct++;
   endtask

   task automatic modelCheck();
      int ph, ePc, eAddr;
      ph = mAct % 8;
      ePc = (ph >= 3) ? (mStart + 1) % 4096 : mStart;
      eAddr = (ph == 0) ? (ePc & 15) : (ph == 1) ? ((ePc >> 4) & 15) :
              (ph == 2) ? ((ePc >> 8) & 15) : 0;
      chk("rnd.cycle", 32'(cycle), 32'(ph));
      chk("rnd.sync", 32'(sync), 32'(ph == 7));
      chk("rnd.pc", 32'(pc), 32'(ePc));
      chk("rnd.addrOut", 32'(addrOut), 32'(eAddr));
      chk("rnd.opr", 32'(opr), 32'(mOpr));
      chk("rnd.opa", 32'(opa), 32'(mOpa));
      chk("rnd.imm", 32'(imm), 32'(mImm));
      chk("rnd.secondWord", 32'(secondWord), 32'(mW2));
   endtask

   // ---------------- JUN vector table ---------------------------------
   typedef struct {
      logic [3:0]  data;
      logic [2:0]  cyc;
      logic [11:0] pcv;
      logic        sw;
      logic [3:0]  oprv;
      logic [3:0]  opav;
      logic [7:0]  immv;
      logic [3:0]  addr;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{4'h0, 3'd1, 12'h000, 1'b0, 4'h0, 4'h0, 8'h00, 4'h0};
      tbl[1]  = '{4'h0, 3'd2, 12'h000, 1'b0, 4'h0, 4'h0, 8'h00, 4'h0};
      tbl[2]  = '{4'h0, 3'd3, 12'h001, 1'b0, 4'h0, 4'h0, 8'h00, 4'h0};
      tbl[3]  = '{4'h4, 3'd4, 12'h001, 1'b0, 4'h4, 4'h0, 8'h00, 4'h0};
      tbl[4]  = '{4'h1, 3'd5, 12'h001, 1'b0, 4'h4, 4'h1, 8'h00, 4'h0};
      tbl[5]  = '{4'h0, 3'd6, 12'h001, 1'b0, 4'h4, 4'h1, 8'h00, 4'h0};
      tbl[6]  = '{4'h0, 3'd7, 12'h001, 1'b0, 4'h4, 4'h1, 8'h00, 4'h0};
      tbl[7]  = '{4'h0, 3'd0, 12'h001, 1'b1, 4'h4, 4'h1, 8'h00, 4'h1};
      tbl[8]  = '{4'h0, 3'd1, 12'h001, 1'b1, 4'h4, 4'h1, 8'h00, 4'h0};
      tbl[9]  = '{4'h0, 3'd2, 12'h001, 1'b1, 4'h4, 4'h1, 8'h00, 4'h0};
      tbl[10] = '{4'h0, 3'd3, 12'h002, 1'b1, 4'h4, 4'h1, 8'h00, 4'h0};
      tbl[11] = '{4'h2, 3'd4, 12'h002, 1'b1, 4'h4, 4'h1, 8'h20, 4'h0};
      tbl[12] = '{4'h3, 3'd5, 12'h002, 1'b1, 4'h4, 4'h1, 8'h23, 4'h0};
      tbl[13] = '{4'h0, 3'd6, 12'h002, 1'b1, 4'h4, 4'h1, 8'h23, 4'h0};
      tbl[14] = '{4'h0, 3'd7, 12'h002, 1'b1, 4'h4, 4'h1, 8'h23, 4'h0};
      tbl[15] = '{4'h0, 3'd0, 12'h123, 1'b0, 4'h4, 4'h1, 8'h23, 4'h3};

      // ---- reset state and free run, including PC wrap on dutWrap ----
      doReset();
      chk("rst.cycle", 32'(cycle), 32'd0);
      chk("rst.pc", 32'(pc), 32'h000);
      chk("rst.sync", 32'(sync), 32'd0);
      chk("rst.addrOut", 32'(addrOut), 32'h0);
      chk("rst.opr", 32'(opr), 32'h0);
      chk("rst.opa", 32'(opa), 32'h0);
      chk("rst.imm", 32'(imm), 32'h00);
      chk("rst.secondWord", 32'(secondWord), 32'd0);
      chk("wrap.rstPc", 32'(wPc), 32'hFFF);
      chk("wrap.rstAddr", 32'(wAddrOut), 32'hF);
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("free.cycle", 32'(cycle), 32'(k % 8));
         chk("free.sync", 32'(sync), 32'((k % 8) == 7));
         chk("free.pc", 32'(pc), (k >= 11) ? 32'd2 : (k >= 3) ? 32'd1 : 32'd0);
         if (k == 8) chk("free.addrA1", 32'(addrOut), 32'h1);
         if (k == 2) chk("wrap.addrA3", 32'(wAddrOut), 32'hF);
         if (k == 3) chk("wrap.pc", 32'(wPc), 32'h000);
         if (k == 8) chk("wrap.addrA1", 32'(wAddrOut), 32'h0);
      end

      // ---- one-word STC: M1=F, M2=A ----
      for (int j = 0; j < 8; j++) begin
         dataIn = (j == 3) ? 4'hF : (j == 4) ? 4'hA : 4'h0;
         step();
         if (j == 3) chk("stc.oprAtM2", 32'(opr), 32'hF);
         if (j == 4) chk("stc.opaAtX1", 32'(opa), 32'hA);
         chk("stc.secondWord", 32'(secondWord), 32'd0);
      end
      chk("stc.pc", 32'(pc), 32'h003);

      // ---- JUN with jumpEn held high for both words ----
      doReset();
      jumpEn   = 1'b1;
      jumpAddr = 12'h123;
      for (int i = 0; i < 16; i++) begin
         dataIn = tbl[i].data;
         step();
         chk("jun.cycle", 32'(cycle), 32'(tbl[i].cyc));
         chk("jun.pc", 32'(pc), 32'(tbl[i].pcv));
         chk("jun.secondWord", 32'(secondWord), 32'(tbl[i].sw));
         chk("jun.opr", 32'(opr), 32'(tbl[i].oprv));
         chk("jun.opa", 32'(opa), 32'(tbl[i].opav));
         chk("jun.imm", 32'(imm), 32'(tbl[i].immv));
         chk("jun.addrOut", 32'(addrOut), 32'(tbl[i].addr));
      end

      // ---- stall for 5 clocks at M1 ----
      doReset();
      for (int k = 0; k < 3; k++) step();
      stallIn = 1'b1;
      dataIn  = 4'h9;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall.cycle", 32'(cycle), 32'd3);
         chk("stall.pc", 32'(pc), 32'h001);
         chk("stall.opr", 32'(opr), 32'h0);
         chk("stall.secondWord", 32'(secondWord), 32'd0);
      end
      stallIn = 1'b0;
      dataIn  = 4'hF;
      step();
      chk("stall.resumeCycle", 32'(cycle), 32'd4);
      chk("stall.resumeOpr", 32'(opr), 32'hF);
      dataIn = 4'h0;
      for (int k = 0; k < 4; k++) step();
      chk("stall.nextA1Cycle", 32'(cycle), 32'd0);
      chk("stall.nextA1Pc", 32'(pc), 32'h001);

      // ---- stall at X3 defers the jump sample ----
      doReset();
      for (int k = 0; k < 7; k++) step();
      jumpEn   = 1'b1;
      jumpAddr = 12'h456;
      stallIn  = 1'b1;
      step();
      step();
      chk("stallX3.cycle", 32'(cycle), 32'd7);
      chk("stallX3.pc", 32'(pc), 32'h001);
      stallIn = 1'b0;
      step();
      chk("stallX3.jumpPc", 32'(pc), 32'h456);
      chk("stallX3.cycleA1", 32'(cycle), 32'd0);

      // ---- async reset at X1 of a JMS second word ----
      doReset();
      for (int k = 1; k <= 13; k++) begin
         dataIn = (k == 4) ? 4'h5 : (k == 5) ? 4'h6 : (k == 12) ? 4'hA : (k == 13) ? 4'hB : 4'h0;
         step();
      end
      chk("jms.secondWord", 32'(secondWord), 32'd1);
      chk("jms.imm", 32'(imm), 32'hAB);
      chk("jms.cycle", 32'(cycle), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("midRst.cycle", 32'(cycle), 32'd0);
      chk("midRst.pc", 32'(pc), 32'h000);
      chk("midRst.secondWord", 32'(secondWord), 32'd0);
      chk("midRst.opr", 32'(opr), 32'h0);
      chk("midRst.opa", 32'(opa), 32'h0);
      chk("midRst.imm", 32'(imm), 32'h00);
      chk("midRst.wrapPc", 32'(wPc), 32'hFFF);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("midRst.firstEdge", 32'(cycle), 32'd1);

      // ---- randomized run against the instruction-level model ----
      doReset();
      modelReset();
      modelCheck();
      for (int n = 0; n < 800; n++) begin
         stallIn  = ($urandom_range(0, 4) == 0);
         dataIn   = 4'($urandom_range(0, 15));
         jumpEn   = 1'($urandom_range(0, 1));
         jumpAddr = 12'($urandom_range(0, 4095));
         step();
         modelEdge();
         modelCheck();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
